// File: rtl/multi_ch_input_port_if.sv
// Avalon-MM slave bus bundle for multi_ch_input_port: address, strobes,
// write data and registered read data.
interface multi_ch_input_port_if #(
    parameter int ADDR_W = 3
) ();
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/multi_ch_input_port.sv
// Multi-channel synchronised input port on Avalon-MM with coherent snapshot.
// Optional macro INPORT_CHANGE_IRQ_EN adds sticky change flags, MASK and irq.
module multi_ch_input_port #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    multi_ch_input_port_if.slave     bus,
    input  logic [NUM_CH*DATA_W-1:0] in_port,
    output logic                     irq
);
    localparam int VW = NUM_CH * DATA_W;

    logic [VW-1:0] s1_q, s1_d;
    logic [VW-1:0] s2_q, s2_d;
    logic [VW-1:0] snap_q, snap_d;
    logic          snap_mode_q, snap_mode_d;
    logic          snap_valid_q, snap_valid_d;
    logic [31:0]   readdata_q, readdata_d;
    logic [31:0]   addr;
    logic          wr;
    logic [31:0]   flag_rd;
    logic [31:0]   mask_rd;
    logic          unused_wdata;

    assign addr         = 32'(bus.address);
    assign wr           = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata;
    assign bus.readdata = readdata_q;

    always_comb begin
        s1_d         = in_port;
        s2_d         = s1_q;
        snap_d       = snap_q;
        snap_mode_d  = snap_mode_q;
        snap_valid_d = snap_valid_q;
        if (wr && addr == 32'd0) snap_mode_d = bus.writedata[0];
        // Snapshot takes s2 as it stood before this edge, so all channels are coherent
        if (wr && addr == 32'd3) begin
            snap_d       = s2_q;
            snap_valid_d = 1'b1;
        end
    end

    // Read mux is registered every cycle regardless of chipselect
    always_comb begin
        readdata_d = '0;
        case (addr)
            32'd0:   readdata_d = {16'd0, 8'(NUM_CH), 6'd0, snap_valid_q, snap_mode_q};
            32'd1:   readdata_d = flag_rd;
            32'd2:   readdata_d = mask_rd;
            default: readdata_d = '0;
        endcase
        for (int n = 0; n < NUM_CH; n++) begin
            if (addr == 32'(4 + n)) begin
                readdata_d = 32'(snap_mode_q ? snap_q[n*DATA_W +: DATA_W]
                                             : s2_q[n*DATA_W +: DATA_W]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q         <= '0;
            s2_q         <= '0;
            snap_q       <= '0;
            snap_mode_q  <= 1'b0;
            snap_valid_q <= 1'b0;
            readdata_q   <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            snap_q       <= snap_d;
            snap_mode_q  <= snap_mode_d;
            snap_valid_q <= snap_valid_d;
            readdata_q   <= readdata_d;
        end
    end

`ifdef INPORT_CHANGE_IRQ_EN
    logic [VW-1:0]     l_q, l_d;
    logic [NUM_CH-1:0] flag_q, flag_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] chg;
    logic [NUM_CH-1:0] w1c;

    // Set wins over a same-cycle write-1-to-clear
    always_comb begin
        l_d    = s2_q;
        mask_d = mask_q;
        w1c    = '0;
        chg    = '0;
        if (wr && addr == 32'd2) mask_d = bus.writedata[NUM_CH-1:0];
        if (wr && addr == 32'd1) w1c = bus.writedata[NUM_CH-1:0];
        for (int n = 0; n < NUM_CH; n++) begin
            chg[n] = s2_q[n*DATA_W +: DATA_W] != l_q[n*DATA_W +: DATA_W];
        end
        flag_d = (flag_q & ~w1c) | chg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_q    <= '0;
            flag_q <= '0;
            mask_q <= '0;
        end else begin
            l_q    <= l_d;
            flag_q <= flag_d;
            mask_q <= mask_d;
        end
    end

    assign flag_rd = 32'(flag_q);
    assign mask_rd = 32'(mask_q);
    assign irq     = |(flag_q & mask_q);
`else
    assign flag_rd = '0;
    assign mask_rd = '0;
    assign irq     = 1'b0;
`endif

endmodule

// File: doc/multi_ch_input_port.md
# multi_ch_input_port

Parametrised multi-channel successor to the single-channel Avalon input PIO, e.g. accelerometer X/Y/Z as one slave. It samples NUM_CH input channels of DATA_W bits each through a two-flop synchroniser. Each channel can be read live or from a coherent all-channel snapshot. Per-channel sticky change flags drive a maskable level interrupt to the NIOS CPU. It sits on the CPU's Avalon-MM bus as a memory-mapped slave with registered read data.

## Interface
- NUM_CH, 3: number of input channels, 1..(2^ADDR_W − 4), max 24
- DATA_W, 16: bits per channel, 1..32
- ADDR_W, 3: word-address width; channel n maps at address 4+n
- clk  in  1  sole clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  ADDR_W  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; a write is chipselect=1 and write_n=0
- writedata  in  32  write data
- in_port  in  NUM_CH*DATA_W  asynchronous inputs; channel n is bits [n*DATA_W +: DATA_W]
- readdata  out  32  registered read data, zero-extended
- irq  out  1  level interrupt, active high

## Operation
- Synchroniser per bit: s1 <= in_port, s2 <= s1. Register l <= s2 holds the previous sample.
- Change detect: chg[n] = (s2_n != l_n).
- Register map:
  - 0 CTRL: R/W bit0 SNAP_MODE; RO bit1 SNAP_VALID; RO [15:8] = NUM_CH; other bits read 0.
  - 1 CHANGE: sticky flags in [NUM_CH−1:0]; write-1-to-clear.
  - 2 MASK: R/W irq enable per channel in [NUM_CH−1:0].
  - 3 SNAP: a write with any data takes a snapshot; reads 0.
  - 4+n DATA_n: returns the snapshot of channel n if SNAP_MODE=1, otherwise s2_n. Data is zero-extended to 32 bits.
  - Any other address reads 0. Writes to read-only or unmapped addresses are ignored.
- Snapshot: on the edge that completes a SNAP write, snap[n] <= s2_n for all n in the same cycle, and SNAP_VALID <= 1. Clearing SNAP_MODE leaves the snapshot contents and SNAP_VALID unchanged.
- Flags: on each edge, flag[n] <= (flag[n] & ~w1c[n]) | chg[n]. A simultaneous set and clear leaves the flag set (set wins).
- irq = |(flag & mask). It is combinational from registers, with no additional delay.
- Reset values:
  - s1, s2, l, snap, flag, mask, SNAP_MODE, SNAP_VALID: 0.
  - readdata: 0; irq: 0.
  - A nonzero input present at reset release therefore sets its flag; this is intended, and software clears it at init.

## Timing
- readdata <= mux(address) on every clock edge, regardless of chipselect. Read latency is 1 cycle; there is no wait state.
- An in_port change settled before edge k produces:
  - s1 new at edge k;
  - s2 new at edge k+1, so a live read addressed at edge k+1 returns the new value at edge k+2;
  - flag set at edge k+2, so irq is high after edge k+2 when the channel is masked in.
- A write takes effect at the edge on which it is presented. A read of the same register at the next edge sees the new value.
- SNAP write and an input change in the same cycle: the snapshot captures the s2 value current before that edge.
- Single-cycle glitches that propagate through s2 set the flag once. A return to the old value sets it again (already set).
- Asserting reset_n low mid-operation clears all state immediately, independent of clk. Outputs hold reset values until the first edge after release.

## Configuration
- INPORT_CHANGE_IRQ_EN defined: change detect, the CHANGE and MASK registers, and irq are built as described above.
- INPORT_CHANGE_IRQ_EN undefined:
  - l, the flags and mask are removed; irq is tied to 0.
  - Addresses 1 and 2 read 0 and ignore writes.
  - The synchroniser, snapshot and data paths are unchanged.

## Test plan
- Live read, NUM_CH=3, DATA_W=16: drive ch1 = 0x1234, wait 3 clk, read address 5 -> readdata = 0x00001234 one cycle after the address; read address 7 -> 0.
- Snapshot coherence:
  - drive ch0/1/2 = 0x0001/0x0002/0x0003; write CTRL = 1 and write SNAP;
  - change inputs to 0xAAAA/0xBBBB/0xCCCC; reads of 4/5/6 -> 1/2/3 and CTRL = 0x0303;
  - write CTRL = 0; read 4 -> 0xAAAA.
- Change irq:
  - MASK = 0b010; ch1 toggles before edge k -> CHANGE bit1 set and irq high after edge k+2;
  - ch0 toggle -> CHANGE bit0 set, irq unaffected by it;
  - write CHANGE = 0b011 -> CHANGE = 0, irq low on the next cycle.
- Set/clear collision: W1C CHANGE bit2 on the same edge that ch2 change is detected -> bit2 remains 1.
- Async reset mid-operation: with irq high and SNAP_VALID = 1, pulse reset_n low between edges -> readdata = 0 and irq = 0 immediately; after release, CTRL reads 0x0300.
- Build without INPORT_CHANGE_IRQ_EN: toggle all inputs -> irq stays 0; addresses 1 and 2 read 0; the snapshot test still passes.
